// File: rtl/nap_seq_pkg.sv
// Shared types and constants for the nucleic-acid processor valve sequencer.
// Valve bit order everywhere: lysis, wash, elute, vertical, horiz, loop_exit, bead_trap, bead_vtl.
package nap_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MIX,
        S_TRAP,
        S_WASH,
        S_ELUTE,
        S_COLLECT,
        S_DONE
    } state_e;

    localparam logic VALVE_CLOSED = 1'b1;

    localparam int NUM_PHASES = 6;
    localparam logic [2:0] PUMP_IDLE = 3'b111;
    localparam logic [2:0] PUMP_PHASE [NUM_PHASES] = '{
        3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010
    };

    typedef logic [7:0] valve_t;

    // 1 = valve opened in that state, indexed by state encoding
    localparam valve_t VALVE_OPEN [8] = '{
        8'h00,  // IDLE
        8'h90,  // LOAD: lysis, vertical
        8'h00,  // MIX
        8'h06,  // TRAP: loop_exit, bead_trap
        8'h56,  // WASH: wash, vertical, loop_exit, bead_trap
        8'h36,  // ELUTE: elute, vertical, loop_exit, bead_trap
        8'h06,  // COLLECT: loop_exit, bead_trap
        8'h00   // DONE
    };

    function automatic valve_t shared_ctl(input state_e s);
        return ~VALVE_OPEN[s];
    endfunction

endpackage

// File: rtl/nap_valve_sequencer_phase_gen.sv
// Six-phase peristaltic pump driver; each phase holds for dwell cycles.
// en is the next-cycle MIX indication, so pump is registered in step with the FSM.
module peristaltic_phase_gen
    import nap_seq_pkg::*;
#(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         pump,
    output logic               rotation_done
);

    logic [2:0]         phase_q, phase_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               act_q, act_d;
    logic [2:0]         pump_q, pump_d;
    logic               last;

    assign last = (cnt_q == dwell - DWELL_W'(1));
    assign rotation_done = act_q && last
                           && (phase_q == 3'(NUM_PHASES - 1));
    assign pump = pump_q;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pump_d  = pump_q;
        if (!en) begin
            act_d   = 1'b0;
            phase_d = '0;
            cnt_d   = '0;
            pump_d  = PUMP_IDLE;
        end else if (!act_q) begin
            act_d   = 1'b1;
            phase_d = '0;
            cnt_d   = '0;
            pump_d  = PUMP_PHASE[0];
        end else if (last) begin
            cnt_d = '0;
            if (phase_q == 3'(NUM_PHASES - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 3'd1;
            end
            pump_d = PUMP_PHASE[phase_d];
        end else begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            cnt_q   <= '0;
            act_q   <= 1'b0;
            pump_q  <= PUMP_IDLE;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pump_q  <= pump_d;
        end
    end

endmodule

// File: rtl/nap_valve_sequencer.sv
// Timed load/mix/trap/wash/elute/collect valve sequencer for the reactor array.
// NAP_SEQ_ABORT_EN adds an abort input that ends any active run with done+err.
module nap_valve_sequencer
    import nap_seq_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int DWELL_W  = 16,
    parameter int MIX_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef NAP_SEQ_ABORT_EN
    input  logic                abort,
`endif
    input  logic [CHANNELS-1:0] chan_mask,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic [MIX_W-1:0]    mix_cycles,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                lysis_ctl,
    output logic                wash_ctl,
    output logic                elute_ctl,
    output logic                vertical_ctl,
    output logic                horiz_ctl,
    output logic                loop_exit_ctl,
    output logic                bead_trap_ctl,
    output logic                bead_vtl_ctl,
    output logic [2:0]          pump,
    output logic [CHANNELS-1:0] collect_ctl,
    output logic [CHANNELS-1:0] waste_ctl
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_e              state_q, state_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [MIX_W-1:0]    rot_q, rot_d;
    logic [CW-1:0]       chan_q, chan_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [MIX_W-1:0]    mix_q, mix_d;
    logic                zchk_q, zchk_d;
    logic                err_q, err_d;

    valve_t              ctl_q, ctl_d;
    logic [CHANNELS-1:0] coll_q, coll_d;
    logic [CHANNELS-1:0] waste_q, waste_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DWELL_W-1:0]  d_eff;
    logic                step_last;
    logic                rot_done;
    logic                nxt_found;
    logic [CW-1:0]       nxt_idx;
    logic [CW-1:0]       first_idx;

    assign d_eff     = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    assign step_last = (cnt_q == d_eff - DWELL_W'(1));

    peristaltic_phase_gen #(
        .DWELL_W(DWELL_W)
    ) u_pump (
        .clk          (clk),
        .rst          (rst),
        .en           (state_d == S_MIX),
        .dwell        (d_eff),
        .pump         (pump),
        .rotation_done(rot_done)
    );

    // Lowest masked channel overall and lowest masked channel above chan_q
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_idx = CW'(i);
            end
            if (mask_q[i] && (i > int'(chan_q))) begin
                nxt_found = 1'b1;
                nxt_idx   = CW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        chan_d  = chan_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        mix_d   = mix_q;
        zchk_d  = zchk_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (zchk_q) begin
                    zchk_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (start) begin
                    mask_d  = chan_mask;
                    dwell_d = dwell;
                    mix_d   = mix_cycles;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    rot_d   = '0;
                    chan_d  = '0;
                    if (chan_mask == '0) begin
                        zchk_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (step_last) begin
                    cnt_d   = '0;
                    state_d = (mix_q == '0) ? S_TRAP : S_MIX;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_MIX: begin
                if (rot_done) begin
                    if (rot_q == mix_q - MIX_W'(1)) begin
                        state_d = S_TRAP;
                    end else begin
                        rot_d = rot_q + MIX_W'(1);
                    end
                end
            end
            S_TRAP, S_WASH: begin
                if (step_last) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_TRAP) ? S_WASH : S_ELUTE;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_ELUTE: begin
                if (step_last) begin
                    cnt_d   = '0;
                    chan_d  = first_idx;
                    state_d = S_COLLECT;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_COLLECT: begin
                if (step_last) begin
                    cnt_d = '0;
                    if (nxt_found) begin
                        chan_d = nxt_idx;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef NAP_SEQ_ABORT_EN
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_DONE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end
`endif
    end

    // Outputs are derived from next state so they land with the state register
    always_comb begin
        ctl_d   = shared_ctl(state_d);
        coll_d  = {CHANNELS{VALVE_CLOSED}};
        waste_d = {CHANNELS{VALVE_CLOSED}};
        if ((state_d == S_TRAP) || (state_d == S_WASH)) begin
            waste_d = ~mask_d;
        end
        if (state_d == S_COLLECT) begin
            coll_d = ~(CHANNELS'(1) << chan_d);
        end
        busy_d = zchk_d
                 || !((state_d == S_IDLE) || (state_d == S_DONE));
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rot_q   <= '0;
            chan_q  <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
            mix_q   <= '0;
            zchk_q  <= 1'b0;
            err_q   <= 1'b0;
            ctl_q   <= {8{VALVE_CLOSED}};
            coll_q  <= {CHANNELS{VALVE_CLOSED}};
            waste_q <= {CHANNELS{VALVE_CLOSED}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
            chan_q  <= chan_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            mix_q   <= mix_d;
            zchk_q  <= zchk_d;
            err_q   <= err_d;
            ctl_q   <= ctl_d;
            coll_q  <= coll_d;
            waste_q <= waste_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {lysis_ctl, wash_ctl, elute_ctl, vertical_ctl,
            horiz_ctl, loop_exit_ctl, bead_trap_ctl,
            bead_vtl_ctl} = ctl_q;

    assign collect_ctl = coll_q;
    assign waste_ctl   = waste_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: doc/nap_valve_sequencer.md
# nap_valve_sequencer

Clocked control sequencer for the multiplexed nucleic-acid processor. It drives the shared valve-control and peristaltic-pump lines plus per-channel collect/waste valves for CHANNELS parallel reactors. It replaces hand-wired static control nets with a parametrised, timed protocol: load → mix → trap → wash → elute → per-channel collect. It sits between the host/test controller and the pneumatic control ports of the reactor array.

## Interface
Parameters:
- CHANNELS, 5, number of parallel reactor channels (1..32)
- DWELL_W, 16, width of the per-step dwell count
- MIX_W, 8, width of the pump-rotation count

Ports (control outputs: 1 = pressurised = valve closed):
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin protocol; sampled only in IDLE
- chan_mask  in  CHANNELS  channels to process; latched on accepted start
- dwell  in  DWELL_W  cycles per step / per pump phase; latched on start; 0 treated as 1
- mix_cycles  in  MIX_W  full pump rotations in MIX; latched on start
- busy  out  1  protocol in progress
- done  out  1  one-cycle pulse at protocol end
- err  out  1  set with done when the latched mask is zero; cleared on next accepted start
- lysis_ctl, wash_ctl, elute_ctl, vertical_ctl, horiz_ctl, loop_exit_ctl, bead_trap_ctl, bead_vtl_ctl  out  1 each  shared valve controls
- pump  out  3  peristaltic pump phases p1..p3
- collect_ctl  out  CHANNELS  per-channel collect valve
- waste_ctl  out  CHANNELS  per-channel waste valve

## Operation
- States: IDLE, LOAD, MIX, TRAP, WASH, ELUTE, COLLECT, DONE.
- Valves open (0) per state. All other valves are closed (1). Only channels in the latched mask are affected.
  - LOAD: lysis, vertical.
  - MIX: pump sequence only.
  - TRAP: loop_exit, bead_trap, waste[masked].
  - WASH: wash, vertical, loop_exit, bead_trap, waste[masked].
  - ELUTE: elute, vertical, loop_exit, bead_trap.
  - COLLECT: loop_exit, bead_trap, collect[k] for the current channel k only.
- horiz_ctl and bead_vtl_ctl stay 1 throughout. They are reserved for a later bead-resuspension step.
- Pump pattern outside MIX is 3'b111. MIX steps through 6 phases: 3'b011, 001, 101, 100, 110, 010. The phase index wraps 5 → 0, and each phase holds for D = max(dwell,1) cycles.
- MIX lasts mix_cycles × 6 × D cycles. If mix_cycles = 0, LOAD goes directly to TRAP.
- LOAD, TRAP, WASH and ELUTE each last D cycles.
- COLLECT scans channels from index 0 upward, skipping unmasked bits. It opens each masked channel for D cycles. Exactly one collect bit is 0 at any time, and consecutive channels are back-to-back with no gap.
- If the latched mask is zero, IDLE → DONE with err = 1. No valve moves.
- DONE lasts one cycle (done = 1, all closed), then returns to IDLE.
- start while busy is ignored. Input changes after latch do not affect the run.

## Timing
- All outputs are registered.
- Reset values: every *_ctl bit and collect/waste bit is 1; pump = 3'b111; busy = 0, done = 0, err = 0; state = IDLE.
- rst mid-run forces the reset values on the next edge and abandons the run. No done pulse is produced.
- Start accepted at edge t: LOAD outputs and busy = 1 are visible from cycle t+1.
- Total busy cycles = 4D + 6·M·D + n·D, where M = mix_cycles and n = popcount(mask). done is asserted in the cycle after the last busy cycle.
- Dwell counter width is DWELL_W. Rotation counter width is MIX_W. Counters do not overflow, because all counts come from latched inputs.

## Configuration
- Macro: NAP_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit). abort high in any non-IDLE state goes to DONE on the next edge: all valves closed, done = 1, err = 1.
- Undefined: no abort port. A run can only be terminated by rst.

## Structure
- Package nap_seq_pkg holds:
  - the state enum
  - VALVE_CLOSED = 1'b1
  - the 6-entry pump phase constant array
  - a per-state shared-valve open-mask constant
- Sub-module peristaltic_phase_gen: inputs en and dwell; outputs pump[2:0] and rotation_done. It holds the phase index and per-phase dwell counter.

## Test plan
- Reset: assert rst 2 cycles → all ctl/collect/waste = 1, pump = 3'b111, busy = 0, done = 0.
- Full run:
  - Setup: CHANNELS=5, dwell=2, mix_cycles=1, mask=5'b10101, start at t.
  - LOAD at t+1..t+2.
  - pump 011,001,101,100,110,010 at 2 cycles each, t+3..t+14.
  - collect[0] low t+21..22, collect[2] low t+23..24, collect[4] low t+25..26.
  - done at t+27.
- Zero mask: start with mask=0 → done = 1 and err = 1 at t+2, no valve bit ever 0.
- Skip mix and dwell=0: mix_cycles=0, dwell=0, mask=5'b00001 → TRAP directly after 1-cycle LOAD; done at t+6.
- Reset mid-COLLECT: all outputs at reset values the next cycle, no done pulse; a new start is accepted normally.
- With NAP_SEQ_ABORT_EN: abort during MIX → next cycle pump = 3'b111, done = 1, err = 1; IDLE the cycle after.
